seg_scan: RTL and testbench
===========================

Name: seg_scan

Overview:
- Hardware display scanner placed directly downstream of the mc8051 port outputs.
- Captures per-digit segment patterns written by firmware through P1 (value) and P3 (digit select, enable, write strobe).
- Time-multiplexes the four digits onto one shared segment bus with one-hot digit enables and an inter-digit blanking gap.
- Firmware writes each digit once; it no longer refreshes the display in a software loop.

Parameters:
- SHOW_CYC, 4096, clock cycles a digit is driven per scan slot (>=1).
- BLANK_CYC, 64, clock cycles all digits are dark between slots (0 = no gap).
- CNT_W, 16, slot timer width; must hold max(SHOW_CYC, BLANK_CYC).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  reset, asynchronous, active-high.
- seg_val  in  8  segment pattern from core P1.
- seg_sel  in  8  core P3: [1:0] digit index, [2] display enable, [3] write strobe, [7:4] ignored.
- seg_out  out  8  shared segment bus, registered.
- dig_en  out  4  one-hot digit enable, active-high, registered.
- frame_tick  out  1  one-cycle pulse at the end of each full 4-digit scan.

Behaviour:
- One clock, Clk. Reset is asynchronous and active-high.
- Reset values:
  - digit regs d0..d3 = 8'h00; seg_out = 8'h00; dig_en = 4'b0000; frame_tick = 0.
  - state = BLANK; idx = 0; timer = 0; strobe_q = 0.
- Write capture:
  - strobe_q registers seg_sel[3] every cycle.
  - Write occurs when seg_sel[3]=1 and strobe_q=0 (rising edge); d[seg_sel[1:0]] <= seg_val on that same edge.
  - A strobe held high writes once. Firmware must set P1 before raising P3[3].
- FSM states: BLANK, SHOW.
  - BLANK:
    - dig_en = 0, seg_out = 0.
    - timer counts 0..BLANK_CYC-1, then goes to SHOW with timer cleared.
    - If BLANK_CYC = 0, BLANK lasts exactly 1 cycle; the reset-exit BLANK also lasts 1 cycle.
  - SHOW:
    - dig_en = onehot(idx) if seg_sel[2]=1, else 0.
    - seg_out = d[idx] if seg_sel[2]=1, else 0.
    - Lasts SHOW_CYC cycles, then goes to BLANK with timer cleared and idx <= idx+1 (3 wraps to 0).
- frame_tick: high for exactly the one cycle following the SHOW(idx=3)->BLANK transition.
- Output latency: outputs are registered from state, idx, d[], and seg_sel[2], so effects appear one cycle after the cause.
  - A write to the currently shown digit changes seg_out 2 cycles after the strobe edge is sampled (capture, then output reg).
  - seg_sel[2] falling mid-SHOW blanks the outputs 1 cycle later; timer and idx keep running, so scan phase is preserved.
- Never more than one dig_en bit is high. dig_en is 0 for at least 1 cycle between different digits.
- Writes during BLANK or to non-shown digits are stored without affecting the current outputs.
- Reset mid-scan:
  - Immediately clears all outputs and digit regs.
  - After release, scanning restarts from BLANK, idx=0.

Test Plan:
- Scan order: SHOW_CYC=4, BLANK_CYC=2. Write d0..d3 = 8'h3F, 8'h06, 8'h5B, 8'h4F with seg_sel[2]=1.
  - Required: dig_en sequence 0001, 0010, 0100, 1000, each high 4 cycles and separated by 2 zero cycles.
  - Required: seg_out matches the shown digit; frame_tick pulses once per 24-cycle frame.
- Strobe edge: hold seg_sel[3]=1 for 10 cycles with seg_sel[1:0]=2 while seg_val changes from 8'h11 to 8'h22 after the first cycle.
  - Required: d2 = 8'h11 only.
- Enable gating: drop seg_sel[2] during the SHOW of digit 1.
  - Required: dig_en=0 and seg_out=0 from the next cycle onward.
  - Re-raise enable: required, the display resumes on the same frame phase, with frame_tick period unchanged.
- Live update: write 8'h7F to digit 0 while digit 0 is shown.
  - Required: seg_out = 8'h7F two cycles after the strobe edge, and dig_en remains 0001.
- Async reset: assert Reset mid-SHOW of digit 3, between clock edges.
  - Required: seg_out=0, dig_en=0, and all digits read 8'h00 immediately.
  - Required: after release, the first SHOW is digit 0.
- No gap: BLANK_CYC=0, SHOW_CYC=1.
  - Required: dig_en alternates onehot, 0, onehot, 0, and frame_tick period is 8 cycles.

Source files
------------

// File: rtl/seg_scan.sv
// Four-digit multiplexed segment display scanner fed from the 8051 port pins.
// Firmware latches a digit pattern once; hardware owns the refresh and blanking.
module seg_scan #(
    parameter int SHOW_CYC  = 4096,
    parameter int BLANK_CYC = 64,
    parameter int CNT_W     = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] seg_val,
    input  logic [7:0] seg_sel,
    output logic [7:0] seg_out,
    output logic [3:0] dig_en,
    output logic       frame_tick
);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // A zero-length gap still spends one cycle in BLANK so digits never touch.
    localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC <= 1) ? {CNT_W{1'b0}} : CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = (SHOW_CYC  <= 1) ? {CNT_W{1'b0}} : CNT_W'(SHOW_CYC - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        logic [3:0] res;
        case (sel)
            2'd0:    res = 4'b0001;
            2'd1:    res = 4'b0010;
            2'd2:    res = 4'b0100;
            2'd3:    res = 4'b1000;
            default: res = 4'b0000;
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] timer_r;
    logic [CNT_W-1:0] timer_s;
    logic [1:0]       idx_r;
    logic [1:0]       idx_s;
    logic             strobe_q_r;
    logic             write_s;
    logic [7:0]       digit_r [4];
    logic [7:0]       seg_out_s;
    logic [3:0]       dig_en_s;
    logic             frame_tick_s;
    logic             unused_sel_s;

    assign unused_sel_s = ^seg_sel[7:4];
    assign write_s      = seg_sel[3] & ~strobe_q_r;

    // Write-strobe edge detector history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            strobe_q_r <= 1'b0;
        end else begin
            strobe_q_r <= seg_sel[3];
        end
    end

    // Digit pattern storage, written once per strobe rising edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) begin
                digit_r[i] <= 8'h00;
            end
        end else if (write_s) begin
            digit_r[seg_sel[1:0]] <= seg_val;
        end
    end

    // Scan sequencer state, slot timer and digit index.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= ST_BLANK;
            timer_r <= {CNT_W{1'b0}};
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_s;
            timer_r <= timer_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state and pre-register output decode; enable gating leaves the timer running.
    always_comb begin
        state_s      = state_r;
        timer_s      = timer_r + TIMER_ONE;
        idx_s        = idx_r;
        seg_out_s    = 8'h00;
        dig_en_s     = 4'b0000;
        frame_tick_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (timer_r >= BLANK_LAST) begin
                    state_s = ST_SHOW;
                    timer_s = {CNT_W{1'b0}};
                end else begin
                    state_s = ST_BLANK;
                    timer_s = timer_r + TIMER_ONE;
                end
            end
            ST_SHOW: begin
                if (seg_sel[2]) begin
                    dig_en_s  = onehot4(idx_r);
                    seg_out_s = digit_r[idx_r];
                end else begin
                    dig_en_s  = 4'b0000;
                    seg_out_s = 8'h00;
                end
                if (timer_r >= SHOW_LAST) begin
                    state_s      = ST_BLANK;
                    timer_s      = {CNT_W{1'b0}};
                    idx_s        = idx_r + 2'd1;
                    frame_tick_s = (idx_r == 2'd3);
                end else begin
                    state_s      = ST_SHOW;
                    timer_s      = timer_r + TIMER_ONE;
                    idx_s        = idx_r;
                    frame_tick_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_BLANK;
                timer_s = {CNT_W{1'b0}};
                idx_s   = 2'd0;
            end
        endcase
    end

    // Registered display outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            seg_out    <= 8'h00;
            dig_en     <= 4'b0000;
            frame_tick <= 1'b0;
        end else begin
            seg_out    <= seg_out_s;
            dig_en     <= dig_en_s;
            frame_tick <= frame_tick_s;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: a 4/2 scanner and a 1/0 no-gap scanner share stimulus.
module tb_seg_scan;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [7:0] seg_val;
    logic [7:0] seg_sel;
    logic [7:0] seg_out;
    logic [3:0] dig_en;
    logic       frame_tick;
    logic [7:0] ng_seg_out;
    logic [3:0] ng_dig_en;
    logic       ng_frame_tick;

    int errors = 0;
    int checks = 0;

    seg_scan #(.SHOW_CYC(4), .BLANK_CYC(2), .CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .seg_val(seg_val), .seg_sel(seg_sel),
        .seg_out(seg_out), .dig_en(dig_en), .frame_tick(frame_tick)
    );

    seg_scan #(.SHOW_CYC(1), .BLANK_CYC(0), .CNT_W(16)) u_ng (
        .Clk(Clk), .Reset(Reset), .seg_val(seg_val), .seg_sel(seg_sel),
        .seg_out(ng_seg_out), .dig_en(ng_dig_en), .frame_tick(ng_frame_tick)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic write_digit(input logic [1:0] idx, input logic [7:0] val);
        seg_val = val;
        seg_sel = {4'h0, 1'b1, 1'b1, idx};
        tick();
        seg_sel[3] = 1'b0;
        tick();
    endtask

    // Waits for a frame_tick of the selected instance, bounded.
    task automatic wait_ft(input string tag, input bit ng);
        bit found = 1'b0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if ((ng ? ng_frame_tick : frame_tick) === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk({tag, "_ft_seen"}, {31'd0, found}, 32'd1);
    endtask

    // Frame after a tick: j=1..24; slot s shows on j = 6s+3 .. 6s+6.
    task automatic run_frame(input string tag, input logic [31:0] vals, input int drop_at);
        int         jj;
        int         slot;
        logic [3:0] e_en;
        logic [7:0] e_seg;
        for (int j = 1; j <= 24; j++) begin
            tick();
            jj   = (j + 23) % 24;
            slot = jj / 6;
            if ((jj % 6) < 2 || (drop_at != 0 && j > drop_at)) begin
                e_en  = 4'b0000;
                e_seg = 8'h00;
            end else begin
                e_en  = 4'(4'b0001 << slot);
                e_seg = vals[slot*8 +: 8];
            end
            chk({tag, "_dig_en"}, {28'd0, dig_en}, {28'd0, e_en});
            chk({tag, "_seg_out"}, {24'd0, seg_out}, {24'd0, e_seg});
            chk({tag, "_frame_tick"}, {31'd0, frame_tick}, {31'd0, (j == 24)});
            if (j == drop_at) seg_sel[2] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         found;
        logic [3:0] e_en;

        Reset   = 1'b1;
        seg_val = 8'h00;
        seg_sel = 8'h00;
        repeat (3) tick();
        chk("rst_seg_out", {24'd0, seg_out}, 32'h00);
        chk("rst_dig_en", {28'd0, dig_en}, 32'h0);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'h0);
        chk("rst_ng_dig_en", {28'd0, ng_dig_en}, 32'h0);
        Reset = 1'b0;

        write_digit(2'd0, 8'h3F);
        write_digit(2'd1, 8'h06);
        write_digit(2'd2, 8'h5B);
        write_digit(2'd3, 8'h4F);
        wait_ft("scan", 1'b0);
        run_frame("scan", {8'h4F, 8'h5B, 8'h06, 8'h3F}, 0);

        // Strobe held high for 10 cycles: only the first value lands.
        seg_val = 8'h11;
        seg_sel = {4'h0, 1'b1, 1'b1, 2'd2};
        tick();
        seg_val = 8'h22;
        repeat (9) tick();
        seg_sel[3] = 1'b0;
        tick();
        wait_ft("strobe", 1'b0);
        run_frame("strobe", {8'h4F, 8'h11, 8'h06, 8'h3F}, 0);

        wait_ft("gate", 1'b0);
        run_frame("gate", {8'h4F, 8'h11, 8'h06, 8'h3F}, 9);
        seg_sel[2] = 1'b1;
        run_frame("resume", {8'h4F, 8'h11, 8'h06, 8'h3F}, 0);

        // Live update of the digit currently on display.
        wait_ft("live", 1'b0);
        repeat (3) tick();
        chk("live_pre_dig_en", {28'd0, dig_en}, 32'h1);
        chk("live_pre_seg", {24'd0, seg_out}, 32'h3F);
        seg_val = 8'h7F;
        seg_sel = {4'h0, 1'b1, 1'b1, 2'd0};
        tick();
        chk("live_capture_seg", {24'd0, seg_out}, 32'h3F);
        chk("live_capture_dig_en", {28'd0, dig_en}, 32'h1);
        seg_sel[3] = 1'b0;
        tick();
        chk("live_seg", {24'd0, seg_out}, 32'h7F);
        chk("live_dig_en", {28'd0, dig_en}, 32'h1);
        tick();
        chk("live_hold_seg", {24'd0, seg_out}, 32'h7F);

        // Asynchronous reset between edges while digit 3 is shown.
        wait_ft("areset", 1'b0);
        repeat (22) tick();
        chk("areset_pre_dig_en", {28'd0, dig_en}, 32'h8);
        #2;
        Reset = 1'b1;
        #1;
        chk("areset_seg_out", {24'd0, seg_out}, 32'h00);
        chk("areset_dig_en", {28'd0, dig_en}, 32'h0);
        chk("areset_d0", {24'd0, dut.digit_r[0]}, 32'h00);
        chk("areset_d1", {24'd0, dut.digit_r[1]}, 32'h00);
        chk("areset_d2", {24'd0, dut.digit_r[2]}, 32'h00);
        chk("areset_d3", {24'd0, dut.digit_r[3]}, 32'h00);
        chk("areset_ng_dig_en", {28'd0, ng_dig_en}, 32'h0);
        repeat (2) tick();
        Reset = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (dig_en !== 4'b0000) begin
                found = 1'b1;
                break;
            end
        end
        chk("areset_first_seen", {31'd0, found}, 32'd1);
        chk("areset_first_dig", {28'd0, dig_en}, 32'h1);
        chk("areset_first_seg", {24'd0, seg_out}, 32'h00);

        // No-gap instance: onehot and zero alternate, frame_tick every 8 cycles.
        wait_ft("nogap", 1'b1);
        for (int j = 1; j <= 16; j++) begin
            tick();
            e_en = ((j % 2) == 1) ? 4'b0000 : 4'(4'b0001 << (((j / 2) + 3) % 4));
            chk("nogap_dig_en", {28'd0, ng_dig_en}, {28'd0, e_en});
            chk("nogap_frame_tick", {31'd0, ng_frame_tick}, {31'd0, ((j % 8) == 0)});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
